// File: rtl/btn_debounce_bank.sv
// rtl/btn_debounce_bank.sv - N-channel synchronised, counter-based button debouncer
// Optional auto-repeat pulses are built only when BTN_REPEAT_EN is defined.
module btn_debounce_bank #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 20,
  parameter int STABLE_CNT = 500000,
  parameter int ACTIVE_LOW = 1,
  parameter int RPT_W      = 24,
  parameter int REPEAT_DLY = 10000000,
  parameter int REPEAT_PER = 2500000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_rise,
  output logic [N_CH-1:0] btn_fall,
  output logic [N_CH-1:0] btn_rpt
);

  if (longint'(STABLE_CNT) < 64'sd1 ||
      longint'(STABLE_CNT) > (longint'(1) << CNT_W) - 64'sd1) begin : g_bad_stable
    $error("btn_debounce_bank: STABLE_CNT out of range");
  end
  if (longint'(REPEAT_DLY) < 64'sd1 || longint'(REPEAT_PER) < 64'sd1 ||
      longint'(REPEAT_DLY) > (longint'(1) << RPT_W) - 64'sd1 ||
      longint'(REPEAT_PER) > (longint'(1) << RPT_W) - 64'sd1) begin : g_bad_repeat
    $error("btn_debounce_bank: REPEAT_DLY/REPEAT_PER out of range");
  end

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [N_CH-1:0]  IDLE_RAW    = {N_CH{ACTIVE_LOW != 0}};

`ifdef BTN_REPEAT_EN
  typedef enum logic {PH_DELAY, PH_PERIOD} phase_t;
  localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DLY - 1);
  localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PER - 1);
`endif

  logic [N_CH-1:0] r_sync1;
  logic [N_CH-1:0] r_sync2;
  logic [N_CH-1:0] w_s;

  // Reset parks the synchroniser at the idle pin level so exit never looks like a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= IDLE_RAW;
      r_sync2 <= IDLE_RAW;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2 ^ IDLE_RAW;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;
    logic             w_accept;

    // Any sample matching the current level restarts the full window.
    always_comb begin
      w_accept  = 1'b0;
      w_cnt_nxt = '0;
      if (w_s[i] != r_level) begin
        if (r_cnt == STABLE_LAST) begin
          w_accept = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt   <= '0;
        r_level <= 1'b0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
      end else begin
        r_cnt  <= w_cnt_nxt;
        r_rise <= w_accept & w_s[i];
        r_fall <= w_accept & ~w_s[i];
        if (w_accept) begin
          r_level <= w_s[i];
        end
      end
    end

    assign btn_level[i] = r_level;
    assign btn_rise[i]  = r_rise;
    assign btn_fall[i]  = r_fall;

`ifdef BTN_REPEAT_EN
    phase_t           r_phase;
    phase_t           w_phase_nxt;
    logic [RPT_W-1:0] r_rcnt;
    logic [RPT_W-1:0] w_rcnt_nxt;
    logic             r_rpt;
    logic             w_rpt_nxt;

    // An accept in either direction restarts the delay phase; only a press pulses.
    always_comb begin
      w_phase_nxt = r_phase;
      w_rcnt_nxt  = '0;
      w_rpt_nxt   = 1'b0;
      if (w_accept) begin
        w_phase_nxt = PH_DELAY;
        w_rpt_nxt   = w_s[i];
      end else if (r_level) begin
        if (r_phase == PH_DELAY && r_rcnt == DLY_LAST) begin
          w_rpt_nxt   = 1'b1;
          w_phase_nxt = PH_PERIOD;
        end else if (r_phase == PH_PERIOD && r_rcnt == PER_LAST) begin
          w_rpt_nxt = 1'b1;
        end else begin
          w_rcnt_nxt = r_rcnt + 1'b1;
        end
      end else begin
        w_phase_nxt = PH_DELAY;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_phase <= PH_DELAY;
        r_rcnt  <= '0;
        r_rpt   <= 1'b0;
      end else begin
        r_phase <= w_phase_nxt;
        r_rcnt  <= w_rcnt_nxt;
        r_rpt   <= w_rpt_nxt;
      end
    end

    assign btn_rpt[i] = r_rpt;
`else
    assign btn_rpt[i] = 1'b0;
`endif
  end

endmodule
